mult_seq_ctrl: RTL and testbench
================================

// Module: mult_seq_ctrl
// PURPOSE
//   Byte-serial operand loader and result sequencer for the shared 8x8 array
//   multiplier behind the tt_um 8-bit pin interface. Accepts operand A, then B, over
//   one valid/ready input bus and drives them onto the combinational multiplier.
//   Waits a fixed settle latency, then captures the 16-bit product and returns it
//   low byte first over a valid/ready output bus.
// PARAMETERS
//   WIDTH    8   operand width; product is 2*WIDTH, returned as two WIDTH-bit beats
//   MUL_LAT  2   cycles allowed for the array multiplier to settle; legal range 1..15
//   CNT_W    8   width of completed-operation counter
// PORTS
//   clk        in   1        single clock, all state on rising edge
//   rst        in   1        synchronous, active-high reset; highest priority
//   abort      in   1        synchronous abort of the current operation
//   in_valid   in   1        operand byte present on in_data
//   in_data    in   WIDTH    operand byte (A first, then B)
//   in_ready   out  1        controller accepts an operand byte this cycle
//   mul_a      out  WIDTH    registered operand A to the array multiplier
//   mul_b      out  WIDTH    registered operand B to the array multiplier
//   mul_p      in   2*WIDTH  product from the array multiplier
//   out_valid  out  1        result beat valid on out_data
//   out_data   out  WIDTH    result beat: prod[WIDTH-1:0], then prod[2W-1:W]
//   out_ready  in   1        consumer accepts the result beat
//   busy       out  1        high in CALC, OUT_LO and OUT_HI
//   ops_count  out  CNT_W    completed products, wraps modulo 2^CNT_W
// BEHAVIOUR
//   - All outputs registered. Reset: state LOAD_A; in_ready=1; out_valid=0; busy=0;
//     out_data, mul_a, mul_b, product register, latency counter and ops_count all 0.
//   - Handshake: a transfer occurs when valid && ready are both high at a rising edge.
//     in_valid with in_ready=0 is ignored, not queued. out_data and out_valid stay
//     stable while out_valid=1 and out_ready=0.
//   - LOAD_A: in_ready=1. On handshake, mul_a<=in_data; go to LOAD_B.
//   - LOAD_B: in_ready=1. On handshake, mul_b<=in_data and counter<=MUL_LAT. The cycle
//     after this handshake is CALC.
//   - CALC: in_ready=0, busy=1. The counter decrements each cycle. On the last CALC
//     cycle, the product register is loaded from mul_p, then the state goes to OUT_LO.
//     The B handshake is cycle 0; CALC spans cycles 1..MUL_LAT; out_valid=1 from
//     cycle MUL_LAT+1.
//   - OUT_LO: out_valid=1, out_data=prod low byte. On handshake, go to OUT_HI and
//     out_data<=prod high byte; out_valid stays 1 with no bubble.
//   - OUT_HI: on handshake, out_valid<=0, ops_count<=ops_count+1 (wraps), in_ready<=1,
//     go to LOAD_A. mul_a and mul_b hold their values until overwritten by the next load.
//   - abort (rst=0): from any state, next cycle is LOAD_A, in_ready=1, out_valid=0,
//     busy=0. ops_count, mul_a and mul_b are unchanged. An in-flight handshake in the
//     same cycle is discarded.
//   - rst during any state, including mid-transfer, restores all reset values next
//     cycle; rst overrides abort.
//   - Product is unsigned. The controller does no arithmetic except counter decrement
//     and the ops_count increment.
// TESTING
//   1 rst=1 for 2 cycles, random inputs -> in_ready=1, out_valid=0, out_data=0,
//     ops_count=0, busy=0.
//   2 A=0x0D, B=0x0B, MUL_LAT=2, out_ready=1 -> out_valid rises cycle 3 after B;
//     beats 0x8F then 0x00; ops_count=1.
//   3 A=0xFF, B=0xFF, out_ready=0 for 5 cycles -> out_data holds 0x01 with out_valid=1;
//     then beats 0x01, 0xFE.
//   4 in_valid=1 with data 0x55 throughout CALC/OUT_LO/OUT_HI -> in_ready=0;
//     mul_a and mul_b unchanged.
//   5 abort in CALC -> next cycle LOAD_A, out_valid=0, ops_count unchanged.
//     rst in OUT_HI -> all reset values, ops_count=0.
//   6 256 back-to-back ops with CNT_W=8 -> ops_count 0xFF then wraps to 0x00;
//     each product is correct.

Source files
------------

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: byte-serial operand loader and result sequencer for a shared
// combinational WIDTHxWIDTH multiplier. Takes A then B over a valid/ready bus,
// holds them on mul_a/mul_b, waits MUL_LAT settle cycles, captures the product
// and returns it low beat first over a valid/ready output bus.
module mult_seq_ctrl #(
    parameter int WIDTH   = 8,
    parameter int MUL_LAT = 2,   // legal range 1..15
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               abort,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_data,
    output logic               in_ready,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    input  logic [2*WIDTH-1:0] mul_p,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    input  logic               out_ready,
    output logic               busy,
    output logic [CNT_W-1:0]   ops_count
);

    // Latency counter only needs to hold 1..15.
    localparam int LAT_W = 4;

    typedef enum logic [2:0] {
        S_LOAD_A,
        S_LOAD_B,
        S_CALC,
        S_OUT_LO,
        S_OUT_HI
    } state_t;

    state_t             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic [WIDTH-1:0]   mul_a_q, mul_a_d;
    logic [WIDTH-1:0]   mul_b_q, mul_b_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [LAT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   ops_q, ops_d;
    logic               busy_q, busy_d;

    logic in_fire, out_fire;
    assign in_fire  = in_valid && in_ready_q;
    assign out_fire = out_valid_q && out_ready;

    // Next-state and next-output computation; abort overrides any handshake.
    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        prod_d      = prod_q;
        cnt_d       = cnt_q;
        ops_d       = ops_q;
        busy_d      = busy_q;
        if (abort) begin
            state_d     = S_LOAD_A;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
        end else begin
            case (state_q)
                S_LOAD_A: if (in_fire) begin
                    mul_a_d = in_data;
                    state_d = S_LOAD_B;
                end
                S_LOAD_B: if (in_fire) begin
                    mul_b_d    = in_data;
                    cnt_d      = LAT_W'(MUL_LAT);
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = S_CALC;
                end
                S_CALC: begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == LAT_W'(1)) begin
                        // Last settle cycle: sample the multiplier and present low beat.
                        prod_d      = mul_p;
                        out_data_d  = mul_p[WIDTH-1:0];
                        out_valid_d = 1'b1;
                        state_d     = S_OUT_LO;
                    end
                end
                S_OUT_LO: begin
                    if (out_fire) begin
                        out_data_d = prod_q[2*WIDTH-1:WIDTH];
                        state_d    = S_OUT_HI;
                    end else begin
                        out_data_d = prod_q[WIDTH-1:0];
                    end
                end
                S_OUT_HI: if (out_fire) begin
                    out_valid_d = 1'b0;
                    ops_d       = ops_q + 1'b1;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_LOAD_A;
                end
                default: begin
                    state_d     = S_LOAD_A;
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            endcase
        end
    end

    // All state and outputs registered; synchronous reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_LOAD_A;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            prod_q      <= '0;
            cnt_q       <= '0;
            ops_q       <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            prod_q      <= prod_d;
            cnt_q       <= cnt_d;
            ops_q       <= ops_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign busy      = busy_q;
    assign ops_count = ops_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl with a behavioural combinational multiplier.
module tb_mult_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        abort = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready;
    logic [7:0]  mul_a, mul_b;
    logic [15:0] mul_p;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready = 1'b0;
    logic        busy;
    logic [7:0]  ops_count;

    int total = 0;
    int bad   = 0;

    mult_seq_ctrl #(.WIDTH(8), .MUL_LAT(2), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .ops_count(ops_count)
    );

    assign mul_p = 16'(mul_a) * 16'(mul_b);

    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    // Returns number of edges after the B handshake until out_valid appears.
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid  = 1'($urandom);
            in_data   = 8'($urandom);
            abort     = 1'($urandom);
            out_ready = 1'($urandom);
            tick();
        end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%h want=00", out_data); end
        total++; if (ops_count !== 8'h00) begin bad++; $display("FAIL reset_ops got=%h want=00", ops_count); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if ({mul_a, mul_b} !== 16'h0) begin bad++; $display("FAIL reset_mul got=%h want=0000", {mul_a, mul_b}); end
        rst = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int n;
        out_ready = 1'b1;
        send(8'h0D);
        send(8'h0B);
        total++; if (busy !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL basic_calc got busy=%b rdy=%b want 1 0", busy, in_ready); end
        wait_valid(n);
        total++; if (n != 2) begin bad++; $display("FAIL basic_latency got=%0d want=2", n); end
        total++; if (out_valid !== 1'b1 || out_data !== 8'h8F) begin bad++; $display("FAIL basic_lo got=%b/%h want=1/8f", out_valid, out_data); end
        tick();
        total++; if (out_valid !== 1'b1 || out_data !== 8'h00) begin bad++; $display("FAIL basic_hi got=%b/%h want=1/00", out_valid, out_data); end
        tick();
        total++; if (out_valid !== 1'b0 || ops_count !== 8'd1 || in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL basic_done got v=%b ops=%0d rdy=%b busy=%b want 0 1 1 0", out_valid, ops_count, in_ready, busy);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_stall();
        int n;
        out_ready = 1'b0;
        send(8'hFF);
        send(8'hFF);
        wait_valid(n);
        total++; if (n != 2) begin bad++; $display("FAIL stall_latency got=%0d want=2", n); end
        for (int i = 0; i < 5; i++) begin
            total++; if (out_valid !== 1'b1 || out_data !== 8'h01) begin bad++; $display("FAIL stall_hold%0d got=%b/%h want=1/01", i, out_valid, out_data); end
            tick();
        end
        out_ready = 1'b1;
        total++; if (out_valid !== 1'b1 || out_data !== 8'h01) begin bad++; $display("FAIL stall_lo got=%b/%h want=1/01", out_valid, out_data); end
        tick();
        total++; if (out_valid !== 1'b1 || out_data !== 8'hFE) begin bad++; $display("FAIL stall_hi got=%b/%h want=1/fe", out_valid, out_data); end
        tick();
        total++; if (out_valid !== 1'b0 || ops_count !== 8'd2) begin bad++; $display("FAIL stall_done got v=%b ops=%0d want 0 2", out_valid, ops_count); end
        out_ready = 1'b0;
    endtask

    task automatic test_in_ignored();
        out_ready = 1'b0;
        send(8'h12);
        send(8'h34);
        in_valid = 1'b1;
        in_data  = 8'h55;
        for (int i = 0; i < 5; i++) begin
            total++; if (in_ready !== 1'b0 || mul_a !== 8'h12 || mul_b !== 8'h34) begin
                bad++; $display("FAIL ign_hold%0d got rdy=%b a=%h b=%h want 0 12 34", i, in_ready, mul_a, mul_b);
            end
            tick();
        end
        total++; if (out_valid !== 1'b1 || out_data !== 8'hA8) begin bad++; $display("FAIL ign_lo got=%b/%h want=1/a8", out_valid, out_data); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++; if (in_ready !== 1'b0 || out_data !== 8'h03 || mul_a !== 8'h12 || mul_b !== 8'h34) begin
            bad++; $display("FAIL ign_hi got rdy=%b d=%h a=%h b=%h want 0 03 12 34", in_ready, out_data, mul_a, mul_b);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++; if (ops_count !== 8'd3 || in_ready !== 1'b1) begin bad++; $display("FAIL ign_done got ops=%0d rdy=%b want 3 1", ops_count, in_ready); end
    endtask

    task automatic test_abort_rst();
        int n;
        send(8'h21);
        send(8'h43);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || ops_count !== 8'd3) begin
            bad++; $display("FAIL abort_state got rdy=%b v=%b busy=%b ops=%0d want 1 0 0 3", in_ready, out_valid, busy, ops_count);
        end
        total++; if (mul_a !== 8'h21 || mul_b !== 8'h43) begin bad++; $display("FAIL abort_mul got=%h%h want=2143", mul_a, mul_b); end
        tick(); tick(); tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL abort_novalid got=%b want=0", out_valid); end
        // Controller back in LOAD_A: a fresh A then B must be accepted normally.
        send(8'h03);
        send(8'h05);
        wait_valid(n);
        total++; if (n != 2 || out_data !== 8'h0F) begin bad++; $display("FAIL abort_reload got n=%0d d=%h want 2 0f", n, out_data); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'h00 || busy !== 1'b0) begin
            bad++; $display("FAIL rst_hi got rdy=%b v=%b d=%h busy=%b want 1 0 00 0", in_ready, out_valid, out_data, busy);
        end
        total++; if (ops_count !== 8'd0 || mul_a !== 8'h00 || mul_b !== 8'h00) begin
            bad++; $display("FAIL rst_hi_regs got ops=%0d a=%h b=%h want 0 00 00", ops_count, mul_a, mul_b);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  a, b;
        logic [15:0] p;
        logic [7:0]  exp_ops;
        int n;
        out_ready = 1'b1;
        exp_ops = 8'd0;
        for (int i = 0; i < 256; i++) begin
            a = 8'(i * 37 + 5);
            b = 8'(i) ^ 8'hA5;
            p = 16'(a) * 16'(b);
            send(a);
            send(b);
            wait_valid(n);
            total++; if (n != 2 || out_data !== p[7:0]) begin bad++; $display("FAIL b2b_lo%0d got n=%0d d=%h want 2 %h", i, n, out_data, p[7:0]); end
            tick();
            total++; if (out_valid !== 1'b1 || out_data !== p[15:8]) begin bad++; $display("FAIL b2b_hi%0d got v=%b d=%h want 1 %h", i, out_valid, out_data, p[15:8]); end
            tick();
            exp_ops = exp_ops + 8'd1;
            total++; if (ops_count !== exp_ops) begin bad++; $display("FAIL b2b_ops%0d got=%h want=%h", i, ops_count, exp_ops); end
            if (i == 254) begin
                total++; if (ops_count !== 8'hFF) begin bad++; $display("FAIL b2b_ff got=%h want=ff", ops_count); end
            end
        end
        total++; if (ops_count !== 8'h00) begin bad++; $display("FAIL b2b_wrap got=%h want=00", ops_count); end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_in_ignored();
        test_abort_rst();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
